sram_sample_reader: RTL and testbench

- Read-side counterpart of the peak-detect capture path. The capture path writes interleaved max/min sample bytes into external async SRAM; this block reads them back one byte per MCU request.
- Owns the read address counter, drives SRAM address and output-enable with a programmable access wait, and returns each byte with a max/min tag.
- Sits between the external SRAM data bus and the MCU parallel read interface.

---
 rtl/sram_sample_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_sram_sample_reader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sample_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sram_sample_reader
//  Description : Read-side counterpart of the peak-detect capture path.
//                Reads interleaved max/min sample bytes back from external
//                async SRAM, one byte per MCU request. Owns the read
//                address counter, drives SRAM address / output-enable with
//                a programmable access wait, and tags each returned byte
//                with its address LSB (0 = max sample, 1 = min sample).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W     SRAM address width; the read counter wraps modulo 2^ADDR_W
//    RD_WAIT    extra CLK cycles SRAM_OE_N is held low before capture (0..15)
//  Ports
//    CLK        system clock, rising edge
//    CLR        asynchronous active-low reset
//    ADDR_LOAD  load ADDR_IN into the read address counter (aborts a read)
//    ADDR_IN    start address
//    RD_REQ     single-cycle read request from the MCU interface
//    SRAM_DATA  SRAM data bus, read direction
//    SRAM_ADDR  SRAM address (= current read address counter)
//    SRAM_OE_N  SRAM output enable, active-low
//    DATA_OUT   last byte read
//    DATA_VALID one-cycle strobe: DATA_OUT / PAIR_TAG are new
//    PAIR_TAG   address bit 0 of the returned byte
//    BUSY       demand read in progress; RD_REQ ignored while high
//  Build option
//    SRAM_READ_PREFETCH_EN  when defined, the next byte is fetched ahead into
//                           an internal prefetch register so a request is
//                           answered on the following edge.
// ============================================================================
module sram_sample_reader #(
    parameter int ADDR_W  = 19,
    parameter int RD_WAIT = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              ADDR_LOAD,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic              RD_REQ,
    input  logic [7:0]        SRAM_DATA,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_OE_N,
    output logic [7:0]        DATA_OUT,
    output logic              DATA_VALID,
    output logic              PAIR_TAG,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0]        c_rd_wait  = 4'(RD_WAIT);
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr,  w_addr;
    logic [3:0]        r_wait,  w_wait;
    logic              r_oe_n,  w_oe_n;
    logic [7:0]        r_data,  w_data;
    logic              r_valid, w_valid;
    logic              r_tag,   w_tag;
    // Demand-read flag. With prefetch enabled it also means "request pending".
    logic              r_busy,  w_busy;

`ifdef SRAM_READ_PREFETCH_EN
    logic [7:0]        r_pf_data,  w_pf_data;
    logic              r_pf_tag,   w_pf_tag;
    logic              r_pf_valid, w_pf_valid;
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wait     <= 4'd0;
            r_oe_n     <= 1'b1;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_tag      <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SRAM_READ_PREFETCH_EN
            r_pf_data  <= 8'h00;
            r_pf_tag   <= 1'b0;
            r_pf_valid <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_wait     <= w_wait;
            r_oe_n     <= w_oe_n;
            r_data     <= w_data;
            r_valid    <= w_valid;
            r_tag      <= w_tag;
            r_busy     <= w_busy;
`ifdef SRAM_READ_PREFETCH_EN
            r_pf_data  <= w_pf_data;
            r_pf_tag   <= w_pf_tag;
            r_pf_valid <= w_pf_valid;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_wait     = r_wait;
        w_oe_n     = r_oe_n;
        w_data     = r_data;
        w_valid    = 1'b0;
        w_tag      = r_tag;
        w_busy     = r_busy;
`ifdef SRAM_READ_PREFETCH_EN
        w_pf_data  = r_pf_data;
        w_pf_tag   = r_pf_tag;
        w_pf_valid = r_pf_valid;

        if (ADDR_LOAD) begin
            // Discard everything fetched or requested and restart the
            // look-ahead from the new address.
            w_addr     = ADDR_IN;
            w_pf_valid = 1'b0;
            w_busy     = 1'b0;
            w_state    = ST_ACCESS;
            w_oe_n     = 1'b0;
            w_wait     = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pf_valid && (RD_REQ || r_busy)) begin
                        // Hand out the prefetched byte and fetch the next one.
                        w_data     = r_pf_data;
                        w_tag      = r_pf_tag;
                        w_valid    = 1'b1;
                        w_pf_valid = 1'b0;
                        w_busy     = 1'b0;
                        w_state    = ST_ACCESS;
                        w_oe_n     = 1'b0;
                        w_wait     = 4'd0;
                    end else if (RD_REQ) begin
                        // Nothing fetched yet (no load since reset): fetch
                        // now and serve once it lands.
                        w_busy  = 1'b1;
                        w_state = ST_ACCESS;
                        w_oe_n  = 1'b0;
                        w_wait  = 4'd0;
                    end
                end
                ST_ACCESS: begin
                    if (RD_REQ) begin
                        w_busy = 1'b1;
                    end
                    if (r_wait == c_rd_wait) begin
                        w_state = ST_CAPTURE;
                    end else begin
                        w_wait = r_wait + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (RD_REQ) begin
                        w_busy = 1'b1;
                    end
                    w_pf_data  = SRAM_DATA;
                    w_pf_tag   = r_addr[0];
                    w_pf_valid = 1'b1;
                    w_addr     = r_addr + c_addr_one;
                    w_oe_n     = 1'b1;
                    w_state    = ST_IDLE;
                end
                default: begin
                    w_state = ST_IDLE;
                    w_oe_n  = 1'b1;
                end
            endcase
        end
`else
        if (ADDR_LOAD) begin
            // Load wins over a same-cycle request and aborts any read.
            w_addr  = ADDR_IN;
            w_state = ST_IDLE;
            w_oe_n  = 1'b1;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (RD_REQ) begin
                        w_state = ST_ACCESS;
                        w_oe_n  = 1'b0;
                        w_busy  = 1'b1;
                        w_wait  = 4'd0;
                    end
                end
                ST_ACCESS: begin
                    if (r_wait == c_rd_wait) begin
                        w_state = ST_CAPTURE;
                    end else begin
                        w_wait = r_wait + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    w_data  = SRAM_DATA;
                    w_tag   = r_addr[0];
                    w_valid = 1'b1;
                    w_addr  = r_addr + c_addr_one;
                    w_oe_n  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
                default: begin
                    w_state = ST_IDLE;
                    w_oe_n  = 1'b1;
                    w_busy  = 1'b0;
                end
            endcase
        end
`endif
    end

    assign SRAM_ADDR  = r_addr;
    assign SRAM_OE_N  = r_oe_n;
    assign DATA_OUT   = r_data;
    assign DATA_VALID = r_valid;
    assign PAIR_TAG   = r_tag;
    assign BUSY       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_sample_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sram_sample_reader
//  Description : Self-checking bench for sram_sample_reader. An async SRAM
//                model answers SRAM_ADDR while SRAM_OE_N is low; expected
//                bytes, tags, addresses and latencies come from a simple
//                address-counter model of the read sequence.
//  Revision    : 1.0 - initial release
//  Build option: SRAM_READ_PREFETCH_EN selects the prefetch scenario.
// ============================================================================
module tb_sram_sample_reader;

    localparam int c_addr_w  = 19;
    localparam int c_rd_wait = 2;
    localparam int c_lat     = c_rd_wait + 2;

    logic                CLK = 1'b0;
    logic                CLR;
    logic                ADDR_LOAD;
    logic [c_addr_w-1:0] ADDR_IN;
    logic                RD_REQ;
    logic [7:0]          SRAM_DATA;
    logic [c_addr_w-1:0] SRAM_ADDR;
    logic                SRAM_OE_N;
    logic [7:0]          DATA_OUT;
    logic                DATA_VALID;
    logic                PAIR_TAG;
    logic                BUSY;

    int checks = 0;
    int errors = 0;
    logic [c_addr_w-1:0] model_addr = '0;

    logic [7:0] mem_ov [logic [c_addr_w-1:0]];

    sram_sample_reader #(
        .ADDR_W  (c_addr_w),
        .RD_WAIT (c_rd_wait)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .ADDR_LOAD  (ADDR_LOAD),
        .ADDR_IN    (ADDR_IN),
        .RD_REQ     (RD_REQ),
        .SRAM_DATA  (SRAM_DATA),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_OE_N  (SRAM_OE_N),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .PAIR_TAG   (PAIR_TAG),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Memory content: explicit overrides, otherwise a hash of the address.
    function automatic logic [7:0] mem_byte(input logic [c_addr_w-1:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
    endfunction

    always_comb SRAM_DATA = SRAM_OE_N ? 8'hEE : mem_byte(SRAM_ADDR);

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [c_addr_w-1:0] a);
        ADDR_LOAD = 1'b1;
        ADDR_IN   = a;
        tick;
        ADDR_LOAD = 1'b0;
        model_addr = a;
    endtask

    // One request; returns latency in edges after the sampling edge, the
    // returned byte/tag, and whether SRAM_ADDR held while OE was low.
    task automatic do_read(output int lat, output logic [7:0] d,
                           output logic t, output logic stable);
        logic [c_addr_w-1:0] a0;
        a0     = SRAM_ADDR;
        stable = 1'b1;
        RD_REQ = 1'b1;
        tick;
        RD_REQ = 1'b0;
        lat    = 0;
        while (DATA_VALID !== 1'b1 && lat < 30) begin
            if (SRAM_OE_N === 1'b0 && SRAM_ADDR !== a0) stable = 1'b0;
            tick;
            lat++;
        end
        d = DATA_OUT;
        t = PAIR_TAG;
    endtask

    task automatic test_reset;
        CLR = 1'b0; ADDR_LOAD = 1'b0; ADDR_IN = '0; RD_REQ = 1'b0;
        repeat (3) tick;
        CLR = 1'b1;
        tick;
        checks++;
        if ({SRAM_OE_N, BUSY, DATA_VALID} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: oe_n/busy/valid=%b required 100", {SRAM_OE_N, BUSY, DATA_VALID});
        end
        checks++;
        if ({DATA_OUT, PAIR_TAG} !== 9'h000) begin
            errors++;
            $display("FAIL reset_data: data=%h tag=%b required 00/0", DATA_OUT, PAIR_TAG);
        end
        checks++;
        if (SRAM_ADDR !== '0) begin
            errors++;
            $display("FAIL reset_addr: addr=%h required 00000", SRAM_ADDR);
        end
    endtask

`ifdef SRAM_READ_PREFETCH_EN
    task automatic test_prefetch;
        int n;
        mem_ov[19'h00040] = 8'h3C;
        mem_ov[19'h00041] = 8'hC3;
        do_load(19'h00040);
        repeat (10) tick;
        checks++;
        if ({SRAM_ADDR, SRAM_OE_N, BUSY, DATA_VALID} !== {19'h00041, 3'b100}) begin
            errors++;
            $display("FAIL pf_idle: addr=%h oe_n=%b busy=%b valid=%b required 00041/1/0/0",
                     SRAM_ADDR, SRAM_OE_N, BUSY, DATA_VALID);
        end
        RD_REQ = 1'b1;
        tick;
        checks++;
        if ({DATA_VALID, DATA_OUT, PAIR_TAG} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL pf_first: valid=%b data=%h tag=%b required 1/3c/0", DATA_VALID, DATA_OUT, PAIR_TAG);
        end
        tick;
        RD_REQ = 1'b0;
        checks++;
        if ({DATA_VALID, BUSY} !== 2'b01) begin
            errors++;
            $display("FAIL pf_pending: valid=%b busy=%b required 0/1", DATA_VALID, BUSY);
        end
        n = 0;
        while (DATA_VALID !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        // Prefetch of 0x41 began at the first request edge; it captures
        // c_lat edges later and is served one edge after that.
        checks++;
        if (n != c_lat) begin
            errors++;
            $display("FAIL pf_second_latency: got %0d required %0d", n, c_lat);
        end
        checks++;
        if ({DATA_OUT, PAIR_TAG, BUSY} !== {8'hC3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pf_second: data=%h tag=%b busy=%b required c3/1/0", DATA_OUT, PAIR_TAG, BUSY);
        end
    endtask
`else
    task automatic test_single_read;
        int lat; logic [7:0] d; logic t, st;
        mem_ov[19'h00010] = 8'hA5;
        do_load(19'h00010);
        do_read(lat, d, t, st);
        checks++;
        if (lat != c_lat) begin
            errors++;
            $display("FAIL single_latency: got %0d required %0d", lat, c_lat);
        end
        checks++;
        if ({d, t} !== {8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL single_data: data=%h tag=%b required a5/0", d, t);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL single_addr_stable: stable=%b required 1", st);
        end
        checks++;
        if (SRAM_ADDR !== 19'h00011) begin
            errors++;
            $display("FAIL single_next_addr: addr=%h required 00011", SRAM_ADDR);
        end
        tick;
        checks++;
        if ({DATA_VALID, BUSY, SRAM_OE_N} !== 3'b001) begin
            errors++;
            $display("FAIL single_strobe_end: valid/busy/oe_n=%b required 001", {DATA_VALID, BUSY, SRAM_OE_N});
        end
        model_addr = 19'h00011;
    endtask

    task automatic test_pairs;
        int lat; logic [7:0] d; logic t, st;
        logic [7:0] exp_d [2];
        exp_d[0] = 8'hF0;
        exp_d[1] = 8'h10;
        mem_ov[19'h00020] = 8'hF0;
        mem_ov[19'h00021] = 8'h10;
        do_load(19'h00020);
        for (int i = 0; i < 2; i++) begin
            do_read(lat, d, t, st);
            checks++;
            if ({d, t} !== {exp_d[i], i[0]} || lat != c_lat) begin
                errors++;
                $display("FAIL pair_%0d: data=%h tag=%b lat=%0d required %h/%b/%0d",
                         i, d, t, lat, exp_d[i], i[0], c_lat);
            end
        end
        model_addr = 19'h00022;
    endtask

    task automatic test_wrap;
        int lat; logic [7:0] d; logic t, st;
        mem_ov[19'h7FFFF] = 8'h5E;
        do_load(19'h7FFFF);
        do_read(lat, d, t, st);
        checks++;
        if ({d, t} !== {8'h5E, 1'b1}) begin
            errors++;
            $display("FAIL wrap_data: data=%h tag=%b required 5e/1", d, t);
        end
        checks++;
        if (SRAM_ADDR !== 19'h00000) begin
            errors++;
            $display("FAIL wrap_addr: addr=%h required 00000", SRAM_ADDR);
        end
        model_addr = '0;
    endtask

    task automatic test_req_collision;
        int nvalid; logic [7:0] d;
        do_load(19'h00030);
        d = 8'h00;
        RD_REQ = 1'b1;
        tick;
        RD_REQ = 1'b0;
        tick;
        RD_REQ = 1'b1;          // lands while the first read is in ACCESS
        tick;
        RD_REQ = 1'b0;
        nvalid = 0;
        repeat (12) begin
            if (DATA_VALID === 1'b1) begin
                nvalid++;
                d = DATA_OUT;
            end
            tick;
        end
        checks++;
        if (nvalid != 1 || d !== mem_byte(19'h00030)) begin
            errors++;
            $display("FAIL collision_req: valids=%0d data=%h required 1/%h", nvalid, d, mem_byte(19'h00030));
        end
        checks++;
        if (SRAM_ADDR !== 19'h00031) begin
            errors++;
            $display("FAIL collision_req_addr: addr=%h required 00031", SRAM_ADDR);
        end
        model_addr = 19'h00031;
    endtask

    task automatic test_load_abort;
        logic [7:0] prev_d; logic prev_t; int nvalid;
        do_load(19'h00050);
        RD_REQ = 1'b1;
        tick;
        RD_REQ = 1'b0;
        tick;
        prev_d = DATA_OUT;
        prev_t = PAIR_TAG;
        ADDR_LOAD = 1'b1;
        ADDR_IN   = 19'h00100;
        tick;
        ADDR_LOAD = 1'b0;
        checks++;
        if ({SRAM_OE_N, BUSY, SRAM_ADDR} !== {2'b10, 19'h00100}) begin
            errors++;
            $display("FAIL abort_state: oe_n=%b busy=%b addr=%h required 1/0/00100", SRAM_OE_N, BUSY, SRAM_ADDR);
        end
        nvalid = 0;
        repeat (8) begin
            if (DATA_VALID === 1'b1) nvalid++;
            tick;
        end
        checks++;
        if (nvalid != 0 || DATA_OUT !== prev_d || PAIR_TAG !== prev_t) begin
            errors++;
            $display("FAIL abort_no_data: valids=%0d data=%h tag=%b required 0/%h/%b",
                     nvalid, DATA_OUT, PAIR_TAG, prev_d, prev_t);
        end
        model_addr = 19'h00100;
    endtask

    task automatic test_load_priority;
        int nvalid;
        ADDR_LOAD = 1'b1;
        ADDR_IN   = 19'h00200;
        RD_REQ    = 1'b1;
        tick;
        ADDR_LOAD = 1'b0;
        RD_REQ    = 1'b0;
        nvalid = 0;
        repeat (8) begin
            if (DATA_VALID === 1'b1 || SRAM_OE_N !== 1'b1) nvalid++;
            tick;
        end
        checks++;
        if (nvalid != 0 || SRAM_ADDR !== 19'h00200 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: activity=%0d addr=%h busy=%b required 0/00200/0", nvalid, SRAM_ADDR, BUSY);
        end
        model_addr = 19'h00200;
    endtask

    task automatic test_reset_mid_read;
        int nvalid;
        do_load(19'h00060);
        RD_REQ = 1'b1;
        tick;
        RD_REQ = 1'b0;
        tick;
        checks++;
        if (SRAM_OE_N !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre: oe_n=%b required 0", SRAM_OE_N);
        end
        #2;
        CLR = 1'b0;
        #1;   // well before the next edge: reset must act at once
        checks++;
        if ({SRAM_OE_N, BUSY, DATA_VALID, DATA_OUT, PAIR_TAG, SRAM_ADDR} !== {3'b100, 8'h00, 1'b0, 19'h0}) begin
            errors++;
            $display("FAIL midreset_async: oe_n=%b busy=%b valid=%b data=%h tag=%b addr=%h required 1/0/0/00/0/00000",
                     SRAM_OE_N, BUSY, DATA_VALID, DATA_OUT, PAIR_TAG, SRAM_ADDR);
        end
        repeat (3) tick;
        CLR = 1'b1;
        nvalid = 0;
        repeat (10) begin
            if (DATA_VALID === 1'b1) nvalid++;
            tick;
        end
        checks++;
        if (nvalid != 0 || SRAM_ADDR !== 19'h0 || SRAM_OE_N !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after: valids=%0d addr=%h oe_n=%b required 0/00000/1", nvalid, SRAM_ADDR, SRAM_OE_N);
        end
        model_addr = '0;
    endtask

    task automatic test_random;
        int lat; logic [7:0] d, exp_d; logic t, st;
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 7) do_load(19'h7FFFE);
            else if ($urandom_range(3) == 0) do_load(19'($urandom()));
            mem_ov[model_addr] = 8'($urandom());
            exp_d = mem_byte(model_addr);
            do_read(lat, d, t, st);
            checks++;
            if (lat != c_lat || d !== exp_d || t !== model_addr[0] || st !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: lat=%0d data=%h tag=%b stable=%b required %0d/%h/%b/1",
                         i, lat, d, t, st, c_lat, exp_d, model_addr[0]);
            end
            model_addr = model_addr + 19'd1;
            checks++;
            if (SRAM_ADDR !== model_addr) begin
                errors++;
                $display("FAIL random_addr_%0d: addr=%h required %h", i, SRAM_ADDR, model_addr);
            end
            repeat ($urandom_range(2)) tick;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
`ifdef SRAM_READ_PREFETCH_EN
        test_prefetch;
`else
        test_single_read;
        test_pairs;
        test_wrap;
        test_req_collision;
        test_load_abort;
        test_load_priority;
        test_reset_mid_read;
        test_random;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
